// File: rtl/shift_sequencer.sv
// Multi-pass 8-bit shifter/rotator: each RUN cycle moves the operand by at most MAX_STEP bits,
// then the result is held in DONE until the consumer takes it.
module shift_sequencer #(
    parameter int unsigned MAX_STEP = 7
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       REQ_VALID,
    output logic       REQ_READY,
    input  logic [7:0] REQ_DATA,
    input  logic [4:0] REQ_AMT,
    input  logic [1:0] REQ_OP,
    output logic       RESP_VALID,
    input  logic       RESP_READY,
    output logic [7:0] RESP_DATA,
    output logic [2:0] PASSES,
    output logic       BUSY
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    localparam logic [2:0] StepMax = 3'(MAX_STEP);

    state_e      state_q, state_d;
    logic [7:0]  data_q, data_d;
    logic [2:0]  rem_q, rem_d;
    logic [1:0]  op_q, op_d;
    logic        sat_q, sat_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [7:0]  resp_q, resp_d;
    logic [2:0]  passes_q, passes_d;

    logic [2:0]  step;
    logic [15:0] rot;
    logic [7:0]  shifted;

    assign REQ_READY  = (state_q == StIdle) && !RESET;
    assign RESP_VALID = (state_q == StDone) && !RESET;
    assign BUSY       = (state_q != StIdle) && !RESET;
    assign RESP_DATA  = resp_q;
    assign PASSES     = passes_q;

    always_comb begin
        step    = (rem_q < StepMax) ? rem_q : StepMax;
        rot     = 16'h0000;
        shifted = data_q;
        unique case (op_q)
            2'b00: shifted = data_q << step;
            2'b01: shifted = data_q >> step;
            2'b10: begin
                rot     = {data_q, data_q} << step;
                shifted = rot[15:8];
            end
            default: begin
                rot     = {data_q, data_q} >> step;
                shifted = rot[7:0];
            end
        endcase
    end

    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        rem_d    = rem_q;
        op_d     = op_q;
        sat_d    = sat_q;
        cnt_d    = cnt_q;
        resp_d   = resp_q;
        passes_d = passes_q;
        unique case (state_q)
            StIdle: begin
                if (REQ_VALID && REQ_READY) begin
                    data_d  = REQ_DATA;
                    op_d    = REQ_OP;
                    cnt_d   = 3'd0;
                    // Rotates wrap mod 8; plain shifts of 8 or more just clear the operand.
                    sat_d   = !REQ_OP[1] && (REQ_AMT[4:3] != 2'b00);
                    rem_d   = sat_d ? 3'd0 : REQ_AMT[2:0];
                    state_d = StRun;
                end
            end
            StRun: begin
                cnt_d = cnt_q + 3'd1;
                if (sat_q) begin
                    data_d = 8'h00;
                    rem_d  = 3'd0;
                end else begin
                    data_d = shifted;
                    rem_d  = rem_q - step;
                end
                if (sat_q || (rem_q == step)) begin
                    state_d  = StDone;
                    resp_d   = sat_q ? 8'h00 : shifted;
                    passes_d = cnt_q + 3'd1;
                end
            end
            StDone: begin
                if (RESP_READY) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= StIdle;
            data_q   <= 8'h00;
            rem_q    <= 3'd0;
            op_q     <= 2'b00;
            sat_q    <= 1'b0;
            cnt_q    <= 3'd0;
            resp_q   <= 8'h00;
            passes_q <= 3'd0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            rem_q    <= rem_d;
            op_q     <= op_d;
            sat_q    <= sat_d;
            cnt_q    <= cnt_d;
            resp_q   <= resp_d;
            passes_q <= passes_d;
        end
    end

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: directed cases, reset abort, back-to-back and random traffic
// against an arithmetic reference of the shift/rotate result and pass count.
module tb_shift_sequencer;

    localparam int unsigned MS = 2;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       REQ_VALID;
    logic       REQ_READY;
    logic [7:0] REQ_DATA;
    logic [4:0] REQ_AMT;
    logic [1:0] REQ_OP;
    logic       RESP_VALID;
    logic       RESP_READY;
    logic [7:0] RESP_DATA;
    logic [2:0] PASSES;
    logic       BUSY;

    int n_cmp = 0;
    int n_err = 0;

    shift_sequencer #(.MAX_STEP(MS)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .REQ_VALID (REQ_VALID),
        .REQ_READY (REQ_READY),
        .REQ_DATA  (REQ_DATA),
        .REQ_AMT   (REQ_AMT),
        .REQ_OP    (REQ_OP),
        .RESP_VALID(RESP_VALID),
        .RESP_READY(RESP_READY),
        .RESP_DATA (RESP_DATA),
        .PASSES    (PASSES),
        .BUSY      (BUSY)
    );

    always #5 CLK = ~CLK;

    initial begin
        #400000;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] ref_data(input logic [7:0] d, input logic [4:0] a,
                                            input logic [1:0] o);
        int x = int'(d);
        int s = int'(a);
        int r = s % 8;
        int y;
        case (o)
            2'd0:    y = (s >= 8) ? 0 : (x << s);
            2'd1:    y = (s >= 8) ? 0 : (x >> s);
            2'd2:    y = (x << r) | (x >> (8 - r));
            default: y = (x >> r) | (x << (8 - r));
        endcase
        return 8'(y & 255);
    endfunction

    function automatic int ref_passes(input logic [4:0] a, input logic [1:0] o);
        int r;
        if (!o[1] && a >= 5'd8) return 1;
        r = o[1] ? int'(a) % 8 : int'(a);
        return (r == 0) ? 1 : (r + int'(MS) - 1) / int'(MS);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic issue(input logic [7:0] d, input logic [4:0] a, input logic [1:0] o);
        int w = 0;
        REQ_VALID = 1'b1;
        REQ_DATA  = d;
        REQ_AMT   = a;
        REQ_OP    = o;
        #1;
        while (!REQ_READY && w < 50) begin
            tick();
            w++;
        end
        chk("ready_before_accept", 32'(REQ_READY), 32'd1);
        tick();
        // Scramble inputs; they must be ignored until the next accept.
        REQ_VALID = 1'b0;
        REQ_DATA  = 8'($urandom);
        REQ_AMT   = 5'($urandom);
        REQ_OP    = 2'($urandom);
        #1;
        chk("busy_after_accept", 32'(BUSY), 32'd1);
        chk("ready_after_accept", 32'(REQ_READY), 32'd0);
    endtask

    task automatic await_resp(input logic [7:0] d, input logic [4:0] a, input logic [1:0] o,
                              input int hold, input bit chain, input logic [7:0] nd,
                              input logic [4:0] na, input logic [1:0] no);
        int lat = 0;
        logic [7:0] exp_d = ref_data(d, a, o);
        int exp_p = ref_passes(a, o);
        while (!RESP_VALID && lat < 40) begin
            tick();
            lat++;
        end
        chk("latency", 32'(lat), 32'(exp_p));
        chk("resp_data", 32'(RESP_DATA), 32'(exp_d));
        chk("passes", 32'(PASSES), 32'(exp_p));
        if (chain) begin
            REQ_DATA = nd;
            REQ_AMT  = na;
            REQ_OP   = no;
        end
        REQ_VALID = 1'b1;
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("hold_valid", 32'(RESP_VALID), 32'd1);
            chk("hold_data", 32'(RESP_DATA), 32'(exp_d));
            chk("hold_ready", 32'(REQ_READY), 32'd0);
        end
        RESP_READY = 1'b1;
        tick();
        RESP_READY = 1'b0;
        if (!chain) REQ_VALID = 1'b0;
        #1;
        chk("post_hs_valid", 32'(RESP_VALID), 32'd0);
        chk("post_hs_ready", 32'(REQ_READY), 32'd1);
        chk("idle_data_kept", 32'(RESP_DATA), 32'(exp_d));
        chk("idle_passes_kept", 32'(PASSES), 32'(exp_p));
    endtask

    task automatic run_op(input logic [7:0] d, input logic [4:0] a, input logic [1:0] o,
                          input int hold);
        issue(d, a, o);
        await_resp(d, a, o, hold, 1'b0, 8'h00, 5'd0, 2'd0);
    endtask

    initial begin
        logic [7:0] cd, nd;
        logic [4:0] ca, na;
        logic [1:0] co, no;
        bit chain;
        int vcount;
        int lat;

        RESET = 1'b1;
        REQ_VALID = 1'b1;
        REQ_DATA = 8'hA5;
        REQ_AMT = 5'd3;
        REQ_OP = 2'd0;
        RESP_READY = 1'b0;
        tick();
        chk("rst_ready", 32'(REQ_READY), 32'd0);
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_valid", 32'(RESP_VALID), 32'd0);
        tick();
        chk("rst_data", 32'(RESP_DATA), 32'h00);
        chk("rst_passes", 32'(PASSES), 32'd0);
        REQ_VALID = 1'b0;
        RESET = 1'b0;
        #1;
        chk("rst_release_ready", 32'(REQ_READY), 32'd1);

        run_op(8'h81, 5'd3, 2'd0, 0);
        chk("sll_81_3", 32'(RESP_DATA), 32'h08);
        run_op(8'h81, 5'd5, 2'd2, 0);
        chk("rol_81_5", 32'(RESP_DATA), 32'h30);
        run_op(8'hF0, 5'd12, 2'd1, 0);
        chk("srl_sat", 32'(RESP_DATA), 32'h00);
        chk("srl_sat_passes", 32'(PASSES), 32'd1);
        run_op(8'h01, 5'd9, 2'd3, 0);
        chk("ror_01_9", 32'(RESP_DATA), 32'h80);
        run_op(8'h5A, 5'd0, 2'd0, 0);
        chk("sll_amt0", 32'(RESP_DATA), 32'h5A);
        chk("sll_amt0_passes", 32'(PASSES), 32'd1);
        run_op(8'hC3, 5'd7, 2'd3, 4);

        // Back-to-back: second request waits on REQ_VALID while the first is in DONE.
        issue(8'h96, 5'd6, 2'd1);
        await_resp(8'h96, 5'd6, 2'd1, 2, 1'b1, 8'h3C, 5'd21, 2'd2);
        issue(8'h3C, 5'd21, 2'd2);
        await_resp(8'h3C, 5'd21, 2'd2, 0, 1'b0, 8'h00, 5'd0, 2'd0);

        // Reset while in RUN.
        issue(8'h81, 5'd7, 2'd2);
        tick();
        tick();
        chk("abort_run_busy", 32'(BUSY), 32'd1);
        chk("abort_run_valid", 32'(RESP_VALID), 32'd0);
        RESET = 1'b1;
        #1;
        chk("abort_rst_ready", 32'(REQ_READY), 32'd0);
        chk("abort_rst_busy", 32'(BUSY), 32'd0);
        tick();
        RESET = 1'b0;
        #1;
        chk("abort_ready", 32'(REQ_READY), 32'd1);
        chk("abort_data", 32'(RESP_DATA), 32'h00);
        chk("abort_passes", 32'(PASSES), 32'd0);
        vcount = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (RESP_VALID) vcount++;
        end
        chk("abort_no_resp", 32'(vcount), 32'd0);

        // Reset while in DONE.
        issue(8'h0F, 5'd2, 2'd0);
        lat = 0;
        while (!RESP_VALID && lat < 40) begin
            tick();
            lat++;
        end
        chk("done_before_rst", 32'(RESP_VALID), 32'd1);
        RESET = 1'b1;
        #1;
        chk("done_rst_valid", 32'(RESP_VALID), 32'd0);
        tick();
        RESET = 1'b0;
        #1;
        chk("done_rst_ready", 32'(REQ_READY), 32'd1);
        chk("done_rst_data", 32'(RESP_DATA), 32'h00);
        tick();
        chk("done_rst_no_resp", 32'(RESP_VALID), 32'd0);

        // Random traffic with random back-pressure and optional queued follow-ups.
        cd = 8'($urandom);
        ca = 5'($urandom);
        co = 2'($urandom);
        issue(cd, ca, co);
        for (int i = 0; i < 40; i++) begin
            nd = 8'($urandom);
            na = 5'($urandom);
            no = 2'($urandom);
            chain = 1'($urandom);
            await_resp(cd, ca, co, int'($urandom_range(0, 3)), chain, nd, na, no);
            if (!chain) begin
                for (int g = 0; g < int'($urandom_range(0, 2)); g++) tick();
            end
            issue(nd, na, no);
            cd = nd;
            ca = na;
            co = no;
        end
        await_resp(cd, ca, co, 1, 1'b0, 8'h00, 5'd0, 2'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/shift_sequencer.md
SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 Parameter: MAX_STEP, default 7, maximum shift distance applied per pass (legal 1..7).
REQ-002 Port: CLK  input  1  single clock; all state updates on rising edge.
REQ-003 Port: RESET  input  1  synchronous, active-high reset.
REQ-004 Port: REQ_VALID  input  1  request present.
REQ-005 Port: REQ_READY  output  1  block can accept a request this cycle.
REQ-006 Port: REQ_DATA  input  8  operand.
REQ-007 Port: REQ_AMT  input  5  shift distance, 0..31.
REQ-008 Port: REQ_OP  input  2  00 SLL, 01 SRL, 10 ROL, 11 ROR.
REQ-009 Port: RESP_VALID  output  1  result available.
REQ-010 Port: RESP_READY  input  1  consumer accepts result.
REQ-011 Port: RESP_DATA  output  8  result.
REQ-012 Port: PASSES  output  3  number of passes used by the most recent completed operation.
REQ-013 Port: BUSY  output  1  high whenever state is not IDLE.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-015 REQ_READY SHALL equal (state==IDLE) and not RESET; RESP_VALID SHALL equal (state==DONE).
REQ-016 Accept SHALL occur on an edge where REQ_VALID and REQ_READY are both high; REQ_DATA/AMT/OP SHALL be latched only at accept and ignored otherwise.
REQ-017 At accept, the remaining count SHALL load as: rotates, REQ_AMT mod 8; shifts with REQ_AMT<8, REQ_AMT; shifts with REQ_AMT>=8, a saturate flag forcing a zero result. State SHALL go to RUN.
REQ-018 Each RUN edge SHALL apply step s = min(remaining, MAX_STEP): SLL x<<s, SRL x>>s (zero fill), ROL/ROR 8-bit rotate by s; remaining SHALL decrease by s.
REQ-019 A saturated shift SHALL complete in one RUN pass with a data value of 0x00.
REQ-020 Remaining==0 at entry to RUN, including REQ_AMT 0, SHALL take one pass with s=0; data SHALL be unchanged.
REQ-021 The RUN pass that brings remaining to 0 SHALL move state to DONE and SHALL update PASSES.
REQ-022 Pass count P SHALL equal max(1, ceil(remaining/MAX_STEP)); RESP_VALID SHALL rise P cycles after the accept edge.
REQ-023 In DONE, RESP_DATA SHALL be held stable until RESP_VALID and RESP_READY are both high; the state SHALL then return to IDLE on that edge.
REQ-024 No request SHALL be accepted in the same cycle as a response handshake; the earliest next accept is the following cycle.
REQ-025 RESP_DATA and PASSES SHALL retain their last values in IDLE and RUN; RESP_DATA SHALL NOT be observed as valid unless RESP_VALID is high.

Reset
REQ-026 With RESET high at an edge, state SHALL become IDLE, RESP_DATA 0x00, PASSES 0, and internal data/remaining 0.
REQ-027 While RESET is high, REQ_READY SHALL be 0, RESP_VALID 0 and BUSY 0; no accept SHALL occur.
REQ-028 RESET during RUN or DONE SHALL discard the operation with no response emitted; REQ_READY SHALL be 1 in the first cycle after RESET falls.

Verification
REQ-029 SLL 0x81 amt 3, MAX_STEP 7 -> RESP_DATA 0x08, PASSES 1, RESP_VALID one cycle after accept.
REQ-030 ROL 0x81 amt 5, MAX_STEP 2 -> steps 2,2,1; RESP_DATA 0x30, PASSES 3, RESP_VALID three cycles after accept.
REQ-031 SRL 0xF0 amt 12 -> 0x00, PASSES 1; ROR 0x01 amt 9 -> 0x80, PASSES 1; SLL 0x5A amt 0 -> 0x5A, PASSES 1.
REQ-032 Hold RESP_READY low for 4 cycles after RESP_VALID rises -> RESP_VALID and RESP_DATA stable, REQ_READY 0, concurrent REQ_VALID ignored; raise RESP_READY -> IDLE next edge, accept possible the cycle after.
REQ-033 ROL amt 7, MAX_STEP 1: pulse RESET after 3 RUN cycles -> IDLE, RESP_VALID never asserted, RESP_DATA 0x00, REQ_READY 1 the cycle after RESET falls.
REQ-034 Back-to-back: two requests queued on REQ_VALID -> each accepted only in IDLE; both results are correct and appear in order.
